// File: rtl/rc_pkg.sv
// Shared definitions for the LIFM expander: FSM encodings, default sizes and
// a helper for counter widths.
package rc_pkg;

  localparam int unsigned DEF_WORD_WIDTH = 8;
  localparam int unsigned DEF_STEP_RANGE = 128;
  localparam int unsigned DEF_LANES      = 8;

  typedef logic [1:0] le_state_t;

  localparam le_state_t LE_IDLE   = 2'd0;
  localparam le_state_t LE_EXPAND = 2'd1;
  localparam le_state_t LE_DONE   = 2'd2;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mt_lane_select.sv
// One expansion lane: picks the dense element addressed by the lowest set bit
// of an MT entry. Purely combinational.
// Optional macro LIFM_EXPANDER_ONEHOT_CHECK_EN adds the multi-hot flag output.
module mt_lane_select
  import rc_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned STEP_RANGE = DEF_STEP_RANGE
) (
  input  logic [STEP_RANGE-1:0]            mt_entry_i,
  input  logic [WORD_WIDTH*STEP_RANGE-1:0] dense_i,
  output logic [WORD_WIDTH-1:0]            data_o,
`ifdef LIFM_EXPANDER_ONEHOT_CHECK_EN
  output logic                             multi_hot_o,
`endif
  output logic                             hit_o
);

  // Scan from the top down so the lowest set bit wins; empty entry yields 0.
  always_comb begin
    data_o = '0;
    for (int k = STEP_RANGE - 1; k >= 0; k--) begin
      if (mt_entry_i[k]) data_o = dense_i[k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  assign hit_o = |mt_entry_i;

`ifdef LIFM_EXPANDER_ONEHOT_CHECK_EN
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot_o = |(mt_entry_i & (mt_entry_i - STEP_RANGE'(1)));
`endif

endmodule

// File: rtl/lifm_expander.sv
// Rebuilds full LIFM columns from a dense column plus its mapping-table
// column, LANES positions per beat over STEP_RANGE/LANES beats.
// Optional macro LIFM_EXPANDER_ONEHOT_CHECK_EN enables multi-hot MT detection
// (mt_error); without it mt_error is tied low.
module lifm_expander
  import rc_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned STEP_RANGE = DEF_STEP_RANGE,
  parameter int unsigned LANES      = DEF_LANES
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable_in,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WORD_WIDTH*STEP_RANGE-1:0]    dense_column,
  input  logic [STEP_RANGE*STEP_RANGE-1:0]    mt_column,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WORD_WIDTH*STEP_RANGE-1:0]    lifm_column,
  output logic [cnt_width(STEP_RANGE)-1:0]    hit_count,
  output logic                                mt_error
);

  localparam int unsigned NBEATS = STEP_RANGE / LANES;
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned HIT_W  = cnt_width(STEP_RANGE);
  localparam int unsigned BEAT_W = cnt_width(LANES);
  localparam int unsigned COL_W  = WORD_WIDTH * STEP_RANGE;
  localparam int unsigned MT_W   = STEP_RANGE * STEP_RANGE;
  localparam int unsigned BMT_W  = LANES * STEP_RANGE;
  localparam int unsigned BRES_W = LANES * WORD_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  le_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COL_W-1:0]   dense_q, dense_d;
  logic [MT_W-1:0]    mt_q, mt_d;
  logic [COL_W-1:0]   res_q, res_d;
  logic [HIT_W-1:0]   hit_q, hit_d;

  logic [BMT_W-1:0]   mt_beat;
  logic [BRES_W-1:0]  beat_data;
  logic [LANES-1:0]   lane_hit;
  logic [BEAT_W-1:0]  beat_hits;
  logic               accept;

  // Accept only from IDLE, or from DONE when the held column retires now.
  assign in_ready = enable_in && !reset &&
                    ((state_q == LE_IDLE) || ((state_q == LE_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Select the MT entries belonging to the current beat.
  always_comb begin
    mt_beat = '0;
    for (int b = 0; b < int'(NBEATS); b++) begin
      if (cnt_q == CNT_W'(b)) mt_beat = mt_q[b*BMT_W +: BMT_W];
    end
  end

`ifdef LIFM_EXPANDER_ONEHOT_CHECK_EN
  logic [LANES-1:0] lane_multi;
  logic             err_q, err_d;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mt_lane_select #(
      .WORD_WIDTH (WORD_WIDTH),
      .STEP_RANGE (STEP_RANGE)
    ) u_lane (
      .mt_entry_i  (mt_beat[l*STEP_RANGE +: STEP_RANGE]),
      .dense_i     (dense_q),
      .data_o      (beat_data[l*WORD_WIDTH +: WORD_WIDTH]),
`ifdef LIFM_EXPANDER_ONEHOT_CHECK_EN
      .multi_hot_o (lane_multi[l]),
`endif
      .hit_o       (lane_hit[l])
    );
  end

  // Per-beat hit total; BEAT_W holds LANES so this cannot wrap.
  always_comb begin
    beat_hits = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      beat_hits = beat_hits + BEAT_W'(lane_hit[l]);
    end
  end

  // Next-state: beat processing in EXPAND, retire in DONE, load on accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dense_d = dense_q;
    mt_d    = mt_q;
    res_d   = res_q;
    hit_d   = hit_q;
`ifdef LIFM_EXPANDER_ONEHOT_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      LE_IDLE: ;
      LE_EXPAND: begin
        for (int b = 0; b < int'(NBEATS); b++) begin
          if (cnt_q == CNT_W'(b)) res_d[b*BRES_W +: BRES_W] = beat_data;
        end
        hit_d = hit_q + HIT_W'(beat_hits);
`ifdef LIFM_EXPANDER_ONEHOT_CHECK_EN
        err_d = err_q | (|lane_multi);
`endif
        if (cnt_q == LAST_BEAT) begin
          cnt_d   = '0;
          state_d = LE_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LE_DONE: begin
        if (out_ready) state_d = LE_IDLE;
      end
      default: state_d = LE_IDLE;
    endcase

    // A DONE-state accept overrides the retire-to-IDLE above.
    if (accept) begin
      dense_d = dense_column;
      mt_d    = mt_column;
      hit_d   = '0;
      cnt_d   = '0;
      state_d = LE_EXPAND;
`ifdef LIFM_EXPANDER_ONEHOT_CHECK_EN
      err_d   = 1'b0;
`endif
    end
  end

  // State registers with asynchronous reset; a reset drops any partial column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LE_IDLE;
      cnt_q   <= '0;
      dense_q <= '0;
      mt_q    <= '0;
      res_q   <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dense_q <= dense_d;
      mt_q    <= mt_d;
      res_q   <= res_d;
      hit_q   <= hit_d;
    end
  end

`ifdef LIFM_EXPANDER_ONEHOT_CHECK_EN
  // Sticky multi-hot flag for the column in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign mt_error = err_q;
`else
  assign mt_error = 1'b0;
`endif

  assign out_valid   = (state_q == LE_DONE);
  assign lifm_column = res_q;
  assign hit_count   = hit_q;

endmodule

// File: tb/tb_lifm_expander.sv
// Directed bench for lifm_expander with STEP_RANGE=8, LANES=2 (4 beats).
// Honours LIFM_EXPANDER_ONEHOT_CHECK_EN for the expected mt_error value.
module tb_lifm_expander;

  localparam int unsigned WW = 8;
  localparam int unsigned SR = 8;
  localparam int unsigned LN = 2;
  localparam int unsigned NB = SR / LN;
  localparam int unsigned CW = WW * SR;
  localparam int unsigned MW = SR * SR;
  localparam int unsigned HW = $clog2(SR + 1);

`ifdef LIFM_EXPANDER_ONEHOT_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          enable_in;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] dense_column;
  logic [MW-1:0] mt_column;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] lifm_column;
  logic [HW-1:0] hit_count;
  logic          mt_error;

  lifm_expander #(
    .WORD_WIDTH (WW),
    .STEP_RANGE (SR),
    .LANES      (LN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_in    (enable_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dense_column (dense_column),
    .mt_column    (mt_column),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .lifm_column  (lifm_column),
    .hit_count    (hit_count),
    .mt_error     (mt_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] dense;
    logic [MW-1:0] mt;
    logic [CW-1:0] lifm;
    logic [HW-1:0] hit;
    logic          err;
  } vec_t;

  vec_t vecs [5];
  int   checks;
  int   failures;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Called #1 after an edge; leaves time at #1 after the accept edge.
  task automatic accept_col(input vec_t v, input string name);
    enable_in    = 1'b1;
    dense_column = v.dense;
    mt_column    = v.mt;
    in_valid     = 1'b1;
    #1;
    check({name, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid     = 1'b0;
    dense_column = '1;
    mt_column    = '1;
  endtask

  // Count edges after the accept edge until out_valid; bounded.
  task automatic wait_out(input string name);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(NB));
  endtask

  task automatic check_out(input vec_t v, input string name);
    check({name, " out_valid"}, 64'(out_valid), 64'd1);
    check({name, " lifm"}, 64'(lifm_column), 64'(v.lifm));
    check({name, " hit_count"}, 64'(hit_count), 64'(v.hit));
    check({name, " mt_error"}, 64'(mt_error), 64'(v.err));
  endtask

  task automatic retire(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " retired"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    checks   = 0;
    failures = 0;

    // identity
    vecs[0] = '{dense: 64'h0706050403020100, mt: 64'h8040201008040201,
                lifm: 64'h0706050403020100, hit: HW'(8), err: 1'b0};
    // redundant fan-out of dense[0] to positions 0,3,6
    vecs[1] = '{dense: 64'hF1F2F3F4F5F6F7AB, mt: 64'h0001000001000001,
                lifm: 64'h00AB0000AB0000AB, hit: HW'(3), err: 1'b0};
    // multi-hot entry 2 = 0x06 selects dense[1]; entry 5 selects dense[7]
    vecs[2] = '{dense: 64'h7799999999221199, mt: 64'h0000800000060000,
                lifm: 64'h0000770000110000, hit: HW'(2), err: ERR_EXP};
    // reversal permutation
    vecs[3] = '{dense: 64'hA7A6A5A4A3A2A1A0, mt: 64'h0102040810204080,
                lifm: 64'hA0A1A2A3A4A5A6A7, hit: HW'(8), err: 1'b0};
    // all-ones entry in the last beat selects dense[0]
    vecs[4] = '{dense: 64'h555555555555553C, mt: 64'hFF00000000000000,
                lifm: 64'h3C00000000000000, hit: HW'(1), err: ERR_EXP};

    reset        = 1'b1;
    enable_in    = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    dense_column = '0;
    mt_column    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset hit_count", 64'(hit_count), 64'd0);
    check("reset lifm", 64'(lifm_column), 64'd0);
    check("reset mt_error", 64'(mt_error), 64'd0);
    reset = 1'b0;
    #1;
    check("idle in_ready", 64'(in_ready), 64'd1);

    // enable_in low blocks acceptance, raising it accepts in that cycle
    enable_in    = 1'b0;
    in_valid     = 1'b1;
    dense_column = vecs[1].dense;
    mt_column    = vecs[1].mt;
    seen         = 1'b0;
    repeat (8) begin
      #1;
      if (in_ready || out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("enable low no accept", 64'(seen), 64'd0);
    enable_in = 1'b1;
    #1;
    check("enable high in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out("enable");
    check_out(vecs[1], "enable");
    retire("enable");

    // table of columns
    for (int i = 0; i < 5; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      accept_col(vecs[i], nm);
      wait_out(nm);
      check_out(vecs[i], nm);
      retire(nm);
    end

    // backpressure: hold 10 cycles, then retire + accept together
    accept_col(vecs[0], "bp");
    wait_out("bp");
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || lifm_column !== vecs[0].lifm || hit_count !== vecs[0].hit) seen = 1'b1;
    end
    check("bp held stable", 64'(seen), 64'd0);
    check_out(vecs[0], "bp held");
    dense_column = vecs[3].dense;
    mt_column    = vecs[3].mt;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    #1;
    check("b2b in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    dense_column = '1;
    mt_column    = '1;
    check("b2b out_valid drop", 64'(out_valid), 64'd0);
    wait_out("b2b");
    check_out(vecs[3], "b2b");
    retire("b2b");

    // reset during EXPAND after two beats
    accept_col(vecs[0], "rst");
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst hit_count", 64'(hit_count), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst lifm", 64'(lifm_column), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen  = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst no stale output", 64'(seen), 64'd0);
    check("rst idle in_ready", 64'(in_ready), 64'd1);
    accept_col(vecs[2], "post-rst");
    wait_out("post-rst");
    check_out(vecs[2], "post-rst");
    retire("post-rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
